// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor from the br_cfg switches, then
// echoes every received byte back out through a small circular FIFO.
module spart_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus
);

  // state  | meaning (state names the bus cycle issued at the next edge)
  // CFG_LO | write divisor low byte to ioaddr 10
  // CFG_HI | write divisor high byte to ioaddr 11, record applied config
  // IDLE   | bus quiet; pick reconfigure, read or write
  // RD     | read received byte from SPART into the FIFO
  // WR     | write FIFO head to SPART transmit register
  // GAP    | bus quiet for GAP_CYCLES so rda/tbr can settle
  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WR, GAP} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  state_t        state, state_nxt;
  logic [3:0]    gap_cnt, gap_cnt_nxt;
  logic [1:0]    br_meta, br_sync, sync_fill;
  logic [1:0]    cfg_sel, cfg_applied;
  logic          latch_lo, latch_hi;
  logic [15:0]   div_now, div_sel;
  logic          cs_nxt, rw_nxt;
  logic [1:0]    addr_nxt;
  logic [7:0]    dout, dout_nxt;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, full, empty;

  function automatic logic [15:0] divisor_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return 16'h0515;
      2'b01:   return 16'h028A;
      2'b10:   return 16'h0144;
      default: return 16'h00A1;
    endcase
  endfunction

  assign div_now = divisor_of(br_sync);
  assign div_sel = divisor_of(cfg_sel);

  // FIFO side effects key off the bus cycle currently on the pins
  assign push  = iocs & iorw;
  assign pop   = iocs & ~iorw & (ioaddr == 2'b00);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign databus = iorw ? 8'hzz : dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_meta   <= 2'b00;
      br_sync   <= 2'b00;
      sync_fill <= 2'b00;
    end else begin
      br_meta   <= br_cfg;
      br_sync   <= br_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    cs_nxt      = 1'b0;
    rw_nxt      = 1'b0;
    addr_nxt    = 2'b00;
    dout_nxt    = 8'h00;
    latch_lo    = 1'b0;
    latch_hi    = 1'b0;
    case (state)
      CFG_LO: begin
        // hold off until the synchronizer has seen the switches after reset
        if (sync_fill[1]) begin
          cs_nxt    = 1'b1;
          addr_nxt  = 2'b10;
          dout_nxt  = div_now[7:0];
          latch_lo  = 1'b1;
          state_nxt = CFG_HI;
        end
      end
      CFG_HI: begin
        cs_nxt      = 1'b1;
        addr_nxt    = 2'b11;
        dout_nxt    = div_sel[15:8];
        latch_hi    = 1'b1;
        state_nxt   = GAP;
        gap_cnt_nxt = 4'(GAP_CYCLES - 1);
      end
      IDLE: begin
        if (br_sync != cfg_applied)
          state_nxt = CFG_LO;
        else if (rda && !full)
          state_nxt = RD;
        else if (tbr && !empty)
          state_nxt = WR;
      end
      RD: begin
        cs_nxt      = 1'b1;
        rw_nxt      = 1'b1;
        state_nxt   = GAP;
        gap_cnt_nxt = 4'(GAP_CYCLES - 1);
      end
      WR: begin
        cs_nxt      = 1'b1;
        dout_nxt    = fifo_mem[rd_ptr];
        state_nxt   = GAP;
        gap_cnt_nxt = 4'(GAP_CYCLES - 1);
      end
      GAP: begin
        if (gap_cnt == 4'd0)
          state_nxt = IDLE;
        else
          gap_cnt_nxt = gap_cnt - 4'd1;
      end
      default: state_nxt = CFG_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CFG_LO;
      gap_cnt     <= 4'd0;
      cfg_sel     <= 2'b00;
      cfg_applied <= 2'b00;
      iocs        <= 1'b0;
      iorw        <= 1'b0;
      ioaddr      <= 2'b00;
      dout        <= 8'h00;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
      iocs    <= cs_nxt;
      iorw    <= rw_nxt;
      ioaddr  <= addr_nxt;
      dout    <= dout_nxt;
      if (latch_lo)
        cfg_sel <= br_sync;
      if (latch_hi)
        cfg_applied <= cfg_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      count  <= count + CW'(1);
    end else if (pop) begin
      rd_ptr <= rd_ptr + PW'(1);
      count  <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= databus;
  end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a SPART model supplies bytes, a monitor checks every
// bus cycle against a byte-queue model, and directed steps pin literal values.
module tb_spart_driver;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda, tbr;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] spart_byte;

  assign databus = iorw ? spart_byte : 8'hzz;

  spart_driver #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] offer_mem [32];
  int         offer_n = 0;
  int         rx_idx = 0;
  logic       pop_pend = 1'b0;
  logic [7:0] mdl_q[$];
  logic [7:0] tx_log[$];
  int         tx_at_rd [32];
  int         rd_cnt = 0, cfg_lo_cnt = 0, cfg_hi_cnt = 0;
  logic       prev_cs = 1'b0;
  logic [1:0] prev_addr = 2'b00;
  logic [1:0] lo_cfg = 2'b00;
  int         idle_run = 100;
  logic [7:0] last_lo = 8'h00, last_hi = 8'h00;
  logic       rd_now = 1'b0, wr_now = 1'b0;

  function automatic logic [15:0] div_of(input logic [1:0] c);
    case (c)
      2'b00:   return 16'h0515;
      2'b01:   return 16'h028A;
      2'b10:   return 16'h0144;
      default: return 16'h00A1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic spart_refresh();
    rda        = (rx_idx < offer_n);
    spart_byte = rda ? offer_mem[rx_idx] : 8'hEE;
  endtask

  task automatic offer(input logic [7:0] b);
    offer_mem[offer_n] = b;
    offer_n++;
    spart_refresh();
  endtask

  // per-cycle bus rules; the SPART model advances one cycle after each read
  task automatic monitor();
    logic [15:0] dv;
    rd_now = 1'b0;
    wr_now = 1'b0;
    if (!rst) begin
      prev_cs  = 1'b0;
      idle_run = 100;
      pop_pend = 1'b0;
      return;
    end
    if (iorw) begin
      chk("rd_bus_release", databus, spart_byte);
      chk("rd_select", {iocs, ioaddr}, 3'b100);
    end
    if (!iocs) begin
      chk("idle_outputs", {iorw, ioaddr, databus}, 0);
    end else begin
      chk("addr_legal", ioaddr != 2'b01, 1);
      if (prev_cs) chk("cs_back_to_back", {prev_addr, ioaddr}, 4'b1011);
      else chk("gap_length", idle_run >= GAP, 1);
      if (iorw) begin
        rd_now = 1'b1;
        chk("rd_rda", rda, 1);
        chk("rd_room", mdl_q.size() < DEPTH, 1);
        mdl_q.push_back(databus);
        if (rd_cnt < 32) tx_at_rd[rd_cnt] = tx_log.size();
        rd_cnt++;
      end else begin
        case (ioaddr)
          2'b00: begin
            wr_now = 1'b1;
            chk("wr_tbr", tbr, 1);
            chk("wr_nonempty", mdl_q.size() > 0, 1);
            if (mdl_q.size() > 0) begin
              chk("wr_data", databus, mdl_q[0]);
              void'(mdl_q.pop_front());
            end
            tx_log.push_back(databus);
          end
          2'b10: begin
            dv = div_of(br_cfg);
            chk("cfg_lo_byte", databus, dv[7:0]);
            lo_cfg  = br_cfg;
            last_lo = databus;
            cfg_lo_cnt++;
          end
          2'b11: begin
            dv = div_of(lo_cfg);
            chk("cfg_hi_byte", databus, dv[15:8]);
            chk("cfg_hi_after_lo", prev_cs && prev_addr == 2'b10, 1);
            last_hi = databus;
            cfg_hi_cnt++;
          end
          default: ;
        endcase
      end
    end
    idle_run  = iocs ? 0 : idle_run + 1;
    prev_cs   = iocs;
    prev_addr = ioaddr;
    if (pop_pend) rx_idx++;
    pop_pend = rd_now;
    spart_refresh();
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin step(); k++; end
    chk(name, tx_log.size() >= n, 1);
  endtask

  task automatic wait_rd(input int n, input int budget, input string name);
    int k = 0;
    while (rd_cnt < n && k < budget) begin step(); k++; end
    chk(name, rd_cnt >= n, 1);
  endtask

  initial begin
    int k, c0, c_lo, c_hi, tx_n;
    rst = 1'b0; br_cfg = 2'b01; tbr = 1'b0; rda = 1'b0; spart_byte = 8'hEE;

    // reset values, then the first configuration for br_cfg = 01
    repeat (3) step();
    chk("rst_outputs", {iocs, iorw, ioaddr, databus}, 0);
    rst = 1'b1;
    k = 0;
    while (!iocs && k < 10) begin step(); k++; end
    chk("first_cs", iocs, 1);
    chk("first_cfg_lo_addr", ioaddr, 2);
    chk("first_cfg_lo_data", databus, 8'h8A);
    step();
    chk("first_cfg_hi_addr", ioaddr, 3);
    chk("first_cfg_hi_data", databus, 8'h02);
    for (int i = 0; i < GAP; i++) begin step(); chk("post_cfg_gap", iocs, 0); end

    // single byte echo
    tbr = 1'b1;
    offer(8'h41);
    wait_tx(1, 40, "echo_single_done");
    chk("echo_single_byte", tx_log.size() > 0 ? int'(tx_log[0]) : -1, 8'h41);
    chk("echo_single_reads", rd_cnt, 1);
    tbr = 1'b0;

    // five bytes against a four-entry buffer
    for (int i = 0; i < 5; i++) offer(8'(8'h30 + i));
    repeat (60) step();
    chk("full_reads", rd_cnt, 5);
    chk("full_rda_held", rda, 1);
    chk("full_model_count", mdl_q.size(), 4);
    tbr = 1'b1;
    wait_tx(6, 200, "burst_done");
    for (int i = 0; i < 5; i++)
      chk("burst_order", tx_log.size() > 1 + i ? int'(tx_log[1 + i]) : -1, 8'h30 + i);
    chk("fifth_read_after_first_wr", tx_at_rd[5], 2);
    chk("burst_reads", rd_cnt, 6);
    tbr = 1'b0;

    // reconfigure 01 -> 11 while holding two bytes
    offer(8'h55);
    offer(8'h66);
    wait_rd(8, 60, "hold_reads");
    repeat (4) step();
    c0 = cfg_hi_cnt;
    br_cfg = 2'b11;
    k = 0;
    while (cfg_hi_cnt == c0 && k < 30) begin step(); k++; end
    chk("reconfig_once", cfg_hi_cnt - c0, 1);
    chk("reconfig_lo", last_lo, 8'hA1);
    chk("reconfig_hi", last_hi, 8'h00);
    chk("reconfig_hold", mdl_q.size(), 2);
    tbr = 1'b1;
    wait_tx(8, 60, "reconfig_echo_done");
    chk("reconfig_echo0", tx_log.size() > 6 ? int'(tx_log[6]) : -1, 8'h55);
    chk("reconfig_echo1", tx_log.size() > 7 ? int'(tx_log[7]) : -1, 8'h66);
    tbr = 1'b0;

    // reset asserted in the middle of a write cycle
    offer(8'h77);
    offer(8'h88);
    wait_rd(10, 60, "pre_reset_reads");
    repeat (3) step();
    tbr = 1'b1;
    k = 0;
    do begin step(); k++; end while (!wr_now && k < 40);
    chk("wr_seen_before_reset", wr_now, 1);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", {iocs, iorw, ioaddr, databus}, 0);
    mdl_q.delete();
    rx_idx   = offer_n;
    pop_pend = 1'b0;
    spart_refresh();
    repeat (2) step();
    rst  = 1'b1;
    c_lo = cfg_lo_cnt;
    c_hi = cfg_hi_cnt;
    tx_n = tx_log.size();
    repeat (40) step();
    chk("post_reset_no_stale_write", tx_log.size(), tx_n);
    chk("post_reset_cfg_lo", cfg_lo_cnt - c_lo, 1);
    chk("post_reset_cfg_hi", cfg_hi_cnt - c_hi, 1);
    chk("post_reset_lo_byte", last_lo, 8'hA1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
